// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and constants for the multi-channel alarm clock.
// Build option: ALARM_SNOOZE_EN enables the snooze state and timer.
package multi_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } chan_state_t;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HRS_MOD = 24;

  typedef struct packed {
    logic [6:0] min;
    logic [6:0] hrs;
  } hhmm_t;

  function automatic logic [6:0] inc_mod(
    input logic [6:0] v,
    input int         m
  );
    return (32'(v) == m - 1) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/multi_alarm_clock_alarm_chan.sv
// One alarm channel: alarm register, ring/snooze timers and FSM.
// Build option: ALARM_SNOOZE_EN adds the SNOOZED state and timer.
module alarm_chan
  import multi_alarm_pkg::*;
#(
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_TIMEOUT = 60
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tick_i,
  input  logic  min_adv_i,
  input  logic  hrs_adv_i,
  input  logic  match_i,
  input  logic  snooze_i,
  input  logic  stop_i,
  input  logic  on_i,
  output hhmm_t alm_q_o,
  output hhmm_t alm_d_o,
  output logic  ringing_o
);

  localparam logic [7:0] RING_LD = 8'(RING_TIMEOUT);

  hhmm_t       alm_q, alm_d;
  chan_state_t state_q, state_d;
  logic [7:0]  ring_q, ring_d;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNZ_LD = 10'(SNOOZE_MIN * 60);
  logic [9:0] snz_q, snz_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_i;
`endif

  // Alarm time edit: advance strobes arrive already qualified by tick
  always_comb begin
    alm_d = alm_q;
    if (min_adv_i) alm_d.min = inc_mod(alm_q.min, MIN_MOD);
    if (hrs_adv_i) alm_d.hrs = inc_mod(alm_q.hrs, HRS_MOD);
  end

  // Channel FSM: on-low > stop > snooze > match > timeout
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (on_i && !stop_i && match_i) begin
          state_d = RINGING;
          ring_d  = RING_LD;
        end
      end
      RINGING: begin
        if (!on_i || stop_i) begin
          state_d = IDLE;
          ring_d  = '0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze_i) begin
          state_d = SNOOZED;
          ring_d  = '0;
          snz_d   = SNZ_LD;
        end
`endif
        else if (match_i) begin
          ring_d = RING_LD;
        end else if (tick_i) begin
          if (ring_q <= 8'd1) begin
            state_d = IDLE;
            ring_d  = '0;
          end else begin
            ring_d = ring_q - 8'd1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZED: begin
        if (!on_i || stop_i) begin
          state_d = IDLE;
          snz_d   = '0;
        end else if (match_i) begin
          state_d = RINGING;
          ring_d  = RING_LD;
          snz_d   = '0;
        end else if (tick_i) begin
          if (snz_q <= 10'd1) begin
            state_d = RINGING;
            ring_d  = RING_LD;
            snz_d   = '0;
          end else begin
            snz_d = snz_q - 10'd1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        ring_d  = '0;
      end
    endcase
  end

  // State, timers and alarm register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alm_q   <= '0;
      state_q <= IDLE;
      ring_q  <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= '0;
`endif
    end else begin
      alm_q   <= alm_d;
      state_q <= state_d;
      ring_q  <= ring_d;
`ifdef ALARM_SNOOZE_EN
      snz_q   <= snz_d;
`endif
    end
  end

  assign alm_q_o   = alm_q;
  assign alm_d_o   = alm_d;
  assign ringing_o = (state_q == RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// HH:MM:SS timekeeper with N_ALARMS independent alarm channels.
// Build option: ALARM_SNOOZE_EN enables per-channel snooze.
module multi_alarm_clock
  import multi_alarm_pkg::*;
#(
  parameter int N_ALARMS     = 2,
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_TIMEOUT = 60,
  localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse,
  input  logic                timeset,
  input  logic                alarmset,
  input  logic                minadv,
  input  logic                hrsadv,
  input  logic [SEL_W-1:0]    alarm_sel,
  input  logic [N_ALARMS-1:0] alarm_on,
  input  logic                snooze,
  input  logic                stop,
  output logic [6:0]          disp_sec,
  output logic [6:0]          disp_min,
  output logic [6:0]          disp_hrs,
  output logic [N_ALARMS-1:0] ringing,
  output logic                buzz
);

  logic [6:0] sec_q, sec_d;
  logic [6:0] min_q, min_d;
  logic [6:0] hrs_q, hrs_d;
  logic [6:0] dmin_q, dmin_d;
  logic [6:0] dhrs_q, dhrs_d;

  hhmm_t alm_q [N_ALARMS];
  hhmm_t alm_d [N_ALARMS];

  logic [N_ALARMS-1:0] edit;
  logic [N_ALARMS-1:0] match;
  logic                sel_ok;
  logic [SEL_W-1:0]    sel_eff;
  logic                show_alm;
  logic                tick_match;

  assign sel_ok   = 32'(alarm_sel) < N_ALARMS;
  assign sel_eff  = sel_ok ? alarm_sel : '0;
  assign show_alm = alarmset && !timeset;

  // Time next-state: carries suppressed while setting the time
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hrs_d = hrs_q;
    if (pulse) begin
      sec_d = inc_mod(sec_q, SEC_MOD);
      if (timeset) begin
        if (minadv) min_d = inc_mod(min_q, MIN_MOD);
        if (hrsadv) hrs_d = inc_mod(hrs_q, HRS_MOD);
      end else if (32'(sec_q) == SEC_MOD - 1) begin
        min_d = inc_mod(min_q, MIN_MOD);
        if (32'(min_q) == MIN_MOD - 1) hrs_d = inc_mod(hrs_q, HRS_MOD);
      end
    end
  end

  // Route alarm edit strobes to the selected channel
  always_comb begin
    edit = '0;
    if (pulse && show_alm && sel_ok) edit[sel_eff] = 1'b1;
  end

  assign tick_match = pulse && !timeset && (sec_d == 7'd0);

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
    assign match[g] = tick_match
                   && (alm_q[g].min == min_d)
                   && (alm_q[g].hrs == hrs_d);

    alarm_chan #(
      .SNOOZE_MIN  (SNOOZE_MIN),
      .RING_TIMEOUT(RING_TIMEOUT)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (pulse),
      .min_adv_i(edit[g] & minadv),
      .hrs_adv_i(edit[g] & hrsadv),
      .match_i  (match[g]),
      .snooze_i (snooze),
      .stop_i   (stop),
      .on_i     (alarm_on[g]),
      .alm_q_o  (alm_q[g]),
      .alm_d_o  (alm_d[g]),
      .ringing_o(ringing[g])
    );
  end

  // Display mux on next-state so outputs track stored state exactly
  always_comb begin
    dmin_d = show_alm ? alm_d[sel_eff].min : min_d;
    dhrs_d = show_alm ? alm_d[sel_eff].hrs : hrs_d;
  end

  // Time and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q  <= '0;
      min_q  <= '0;
      hrs_q  <= '0;
      dmin_q <= '0;
      dhrs_q <= '0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hrs_q  <= hrs_d;
      dmin_q <= dmin_d;
      dhrs_q <= dhrs_d;
    end
  end

  assign disp_sec = sec_q;
  assign disp_min = dmin_q;
  assign disp_hrs = dhrs_q;
  assign buzz     = |ringing;

endmodule
